fp32_addsub_comb: RTL and testbench

- Single-precision IEEE-754 adder/subtractor: result = dina + dinb (op=0) or dina − dinb (op=1).
- Arithmetic is one combinational datapath: unpack, align, add/subtract, normalize, round, pack.
- A single output register stage captures the result and the valid flag.
- Used as the basic FP32 add/sub primitive in the wavelet filter datapath.

---
 rtl/fp32_addsub_comb.sv | 130 +++++++++++++
 tb/tb_fp32_addsub_comb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_addsub_comb.sv
// Single-precision IEEE-754 adder/subtractor: one combinational datapath
// (unpack, align, add, normalize, round-to-nearest-even, pack) feeding one output register.
module fp32_addsub_comb (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] dina,
    input  logic [31:0] dinb,
    input  logic        op,
    input  logic        valid_in,
    output logic [31:0] result,
    output logic        valid_out
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sign_a, sign_b, eff_sub;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        nan_a, nan_b, inf_a, inf_b, a_big;

    // Subtraction is addition with B's sign flipped, NaNs included.
    assign sign_a  = dina[31];
    assign sign_b  = dinb[31] ^ op;
    assign exp_a   = dina[30:23];
    assign exp_b   = dinb[30:23];
    assign frac_a  = dina[22:0];
    assign frac_b  = dinb[22:0];
    assign nan_a   = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b   = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign inf_a   = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b   = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign eff_sub = sign_a ^ sign_b;
    assign a_big   = dina[30:0] >= dinb[30:0];

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    logic        sign_big;
    logic [7:0]  exp_big, exp_small, diff, max_shift, shift_amt;
    logic [23:0] man_big, man_small;
    logic [53:0] shift_full;
    logic [26:0] big_al, small_al, norm_m;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_r;
    logic [24:0] mant_r;
    logic [22:0] frac_r;
    logic        round_up, hidden;
    logic [31:0] packed_res;
    logic [31:0] result_d, result_q;
    logic        valid_d, valid_q;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), so no latches are inferred.
    always_comb begin
        sign_big  = a_big ? sign_a : sign_b;
        exp_big   = a_big ? exp_a : exp_b;
        exp_small = a_big ? exp_b : exp_a;
        man_big   = a_big ? {exp_a != 8'd0, frac_a} : {exp_b != 8'd0, frac_b};
        man_small = a_big ? {exp_b != 8'd0, frac_b} : {exp_a != 8'd0, frac_a};
        // Subnormals use effective exponent 1 with a hidden bit of 0.
        if (exp_big == 8'd0)   exp_big = 8'd1;
        if (exp_small == 8'd0) exp_small = 8'd1;
        diff = exp_big - exp_small;

        // Low 27 bits of the wide shift are everything that falls past sticky.
        big_al     = {man_big, 3'b000};
        shift_full = {man_small, 3'b000, 27'd0} >> diff;
        if (diff >= 8'd27) small_al = {26'd0, |man_small};
        else               small_al = {shift_full[53:28], shift_full[27] | (|shift_full[26:0])};

        sum = eff_sub ? ({1'b0, big_al} - {1'b0, small_al})
                      : ({1'b0, big_al} + {1'b0, small_al});

        lz        = lzc27(sum[26:0]);
        max_shift = exp_big - 8'd1;
        shift_amt = ({3'b000, lz} > max_shift) ? max_shift : {3'b000, lz};
        if (sum[27]) begin
            norm_m = {sum[27:2], sum[1] | sum[0]};
            exp_n  = {2'b00, exp_big} + 10'd1;
        end else begin
            norm_m = sum[26:0] << shift_amt;
            exp_n  = {2'b00, exp_big} - {2'b00, shift_amt};
        end

        round_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        mant_r   = {1'b0, norm_m[26:3]} + {24'd0, round_up};
        exp_r    = exp_n + {9'd0, mant_r[24]};
        frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        hidden   = mant_r[24] | mant_r[23];

        if (nan_a || nan_b || (inf_a && inf_b && eff_sub))
            packed_res = QNAN;
        else if (inf_a)
            packed_res = {sign_a, 8'hFF, 23'd0};
        else if (inf_b)
            packed_res = {sign_b, 8'hFF, 23'd0};
        else if (sum == 28'd0)
            packed_res = {~eff_sub & sign_big, 31'd0};
        else if (exp_r >= 10'd255)
            packed_res = {sign_big, 8'hFF, 23'd0};
        else
            packed_res = {sign_big, hidden ? exp_r[7:0] : 8'h00, frac_r};

        result_d = valid_in ? packed_res : result_q;
        valid_d  = valid_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rstn) begin
            result_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_fp32_addsub_comb.sv
// Directed bench for fp32_addsub_comb: hand-computed vectors for arithmetic,
// rounding, specials and subnormals, plus valid/reset/hold control behaviour.
module tb_fp32_addsub_comb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] dina, dinb;
    logic        op;
    logic        valid_in;
    logic [31:0] result;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    fp32_addsub_comb dut (
        .clk       (clk),
        .rstn      (rstn),
        .dina      (dina),
        .dinb      (dinb),
        .op        (op),
        .valid_in  (valid_in),
        .result    (result),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1, "watchdog expired");
    end

    // Drive one operation at the falling edge; sample 1 ns after the capturing edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                         output logic [31:0] res, output logic vld);
        @(negedge clk);
        dina = a; dinb = b; op = o; valid_in = 1'b1;
        @(posedge clk);
        #1;
        res = result;
        vld = valid_out;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle_cycle(output logic [31:0] res, output logic vld);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        res = result;
        vld = valid_out;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic v;
        rstn = 1'b1; valid_in = 1'b0; dina = 32'h0; dinb = 32'h0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h valid=%b, required result=00000000 valid=0", result, valid_out);
        end
        @(negedge clk);
        rstn = 1'b0;
        idle_cycle(r, v);
        checks++;
        if (r !== 32'h0 || v !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: result=%h valid=%b, required 00000000/0", r, v);
        end
    endtask

    task automatic test_basic;
        logic [31:0] r;
        logic v;
        do_op(32'h3F800000, 32'h40000000, 1'b0, r, v);
        checks++;
        if (r !== 32'h40400000 || v !== 1'b1) begin
            errors++;
            $display("FAIL add_1_2: result=%h valid=%b, required 40400000/1", r, v);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycle(r, v);
            checks++;
            if (r !== 32'h40400000 || v !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle%0d: result=%h valid=%b, required 40400000/0", i, r, v);
            end
        end
        do_op(32'h3F800000, 32'h40000000, 1'b1, r, v);
        checks++;
        if (r !== 32'hBF800000 || v !== 1'b1) begin
            errors++;
            $display("FAIL sub_1_2: result=%h valid=%b, required BF800000/1", r, v);
        end
        idle_cycle(r, v);
        checks++;
        if (r !== 32'hBF800000 || v !== 1'b0) begin
            errors++;
            $display("FAIL sub_pulse_end: result=%h valid=%b, required BF800000/0", r, v);
        end
    endtask

    task automatic test_zero;
        logic [31:0] va[3] = '{32'h3F800000, 32'h80000000, 32'h00000000};
        logic [31:0] vb[3] = '{32'h3F800000, 32'h80000000, 32'h80000000};
        logic        vo[3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ve[3] = '{32'h00000000, 32'h80000000, 32'h00000000};
        logic [31:0] r;
        logic v;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vo[i], r, v);
            checks++;
            if (r !== ve[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL zero%0d: %h op%b %h -> %h valid=%b, required %h/1", i, va[i], vo[i], vb[i], r, v, ve[i]);
            end
        end
    endtask

    task automatic test_round;
        logic [31:0] va[4] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800003};
        logic [31:0] vb[4] = '{32'h33800000, 32'h33800000, 32'h33800001, 32'h33800000};
        logic [31:0] ve[4] = '{32'h3F800000, 32'h3F800002, 32'h3F800001, 32'h3F800004};
        logic [31:0] r;
        logic v;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, r, v);
            checks++;
            if (r !== ve[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL round%0d: %h + %h -> %h valid=%b, required %h/1", i, va[i], vb[i], r, v, ve[i]);
            end
        end
    endtask

    task automatic test_special;
        logic [31:0] va[6] = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'hFF7FFFFF};
        logic [31:0] vb[6] = '{32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h7F7FFFFF, 32'h7F800001, 32'h7F7FFFFF};
        logic        vo[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ve[6] = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'hFF800000};
        logic [31:0] r;
        logic v;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vo[i], r, v);
            checks++;
            if (r !== ve[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL special%0d: %h op%b %h -> %h valid=%b, required %h/1", i, va[i], vo[i], vb[i], r, v, ve[i]);
            end
        end
    endtask

    task automatic test_subnormal;
        logic [31:0] va[4] = '{32'h00000001, 32'h00800000, 32'h007FFFFF, 32'h00000003};
        logic [31:0] vb[4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005};
        logic        vo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ve[4] = '{32'h00000002, 32'h007FFFFF, 32'h00800000, 32'h80000002};
        logic [31:0] r;
        logic v;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vo[i], r, v);
            checks++;
            if (r !== ve[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL subnormal%0d: %h op%b %h -> %h valid=%b, required %h/1", i, va[i], vo[i], vb[i], r, v, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va[3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        logic [31:0] vb[3] = '{32'h3F800000, 32'h3F800000, 32'h40400000};
        logic        vo[3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ve[3] = '{32'h40000000, 32'h3F800000, 32'h40C00000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dina = va[i]; dinb = vb[i]; op = vo[i]; valid_in = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (result !== ve[i] || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d: result=%h valid=%b, required %h/1", i, result, valid_out, ve[i]);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h40C00000 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: result=%h valid=%b, required 40C00000/0", result, valid_out);
        end
    endtask

    task automatic test_reset_vs_valid;
        @(negedge clk);
        dina = 32'h3F800000; dinb = 32'h3F800000; op = 1'b0; valid_in = 1'b1; rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: result=%h valid=%b, required 00000000/0", result, valid_out);
        end
        @(negedge clk);
        rstn = 1'b0; valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: result=%h valid=%b, required 00000000/0", result, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_round();
        test_special();
        test_subnormal();
        test_back_to_back();
        test_reset_vs_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
